// File: rtl/ycbcr_pkg.sv
// Shared types and widths for the YCbCr skin-centroid tracker.
package ycbcr_pkg;

  localparam int CNT_W    = 17;
  localparam int SUM_W    = 25;
  localparam int CX_W     = 9;
  localparam int CY_W     = 8;
  localparam int DIV_ITER = 25;
  localparam int ITER_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } trk_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle after a start pulse.
module seq_divider
  import ycbcr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  logic [SUM_W-1:0]  quot_r;
  logic [CNT_W-1:0]  rem_r;
  logic [CNT_W-1:0]  dvs_r;
  logic [ITER_W-1:0] iter_r;
  logic              done_r;
  logic [CNT_W:0]    rem_sh_s;
  logic [CNT_W-1:0]  diff_s;
  logic              ge_s;

  // Trial subtraction for the current step; low bits of the difference suffice when it fits
  always_comb begin
    rem_sh_s = {rem_r, quot_r[SUM_W-1]};
    ge_s     = (rem_sh_s >= {1'b0, dvs_r});
    diff_s   = rem_sh_s[CNT_W-1:0] - dvs_r;
  end

  // Operand load on start, then shift/subtract until the iteration count runs out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_r <= {SUM_W{1'b0}};
      rem_r  <= {CNT_W{1'b0}};
      dvs_r  <= {CNT_W{1'b0}};
      iter_r <= {ITER_W{1'b0}};
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        quot_r <= dividend;
        rem_r  <= {CNT_W{1'b0}};
        dvs_r  <= divisor;
        iter_r <= ITER_W'(DIV_ITER);
      end else if (iter_r != {ITER_W{1'b0}}) begin
        quot_r <= {quot_r[SUM_W-2:0], ge_s};
        rem_r  <= ge_s ? diff_s : rem_sh_s[CNT_W-1:0];
        iter_r <= iter_r - ITER_W'(1);
        done_r <= (iter_r == ITER_W'(1));
      end
    end
  end

  assign quotient = quot_r;
  assign done     = done_r;

endmodule

// File: rtl/skin_centroid_tracker.sv
// Classifies YCbCr pixels as skin, accumulates per-frame coordinate sums and
// reports the skin centroid once the last pixel of a frame has been seen.
module skin_centroid_tracker
  import ycbcr_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int CB_MIN     = 77,
  parameter int CB_MAX     = 127,
  parameter int CR_MIN     = 133,
  parameter int CR_MAX     = 173,
  parameter int MIN_PIXELS = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      y_in,
  input  logic [7:0]      cb_in,
  input  logic [7:0]      cr_in,
  input  logic            valid_in,
  input  logic            frame_start,
  output logic            skin_mask,
  output logic            mask_valid,
  output logic [CX_W-1:0] centroid_x,
  output logic [CY_W-1:0] centroid_y,
  output logic [CNT_W-1:0] pixel_count,
  output logic            centroid_valid,
  output logic            detected,
  output logic            busy
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES + 1) : 1;

  trk_state_e state_r, state_nxt_s;
  logic [XW-1:0]    x_r, x_base_s, x_nxt_s;
  logic [YW-1:0]    y_r, y_base_s, y_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_base_s, cnt_nxt_s, snap_cnt_r;
  logic [SUM_W-1:0] sx_r, sx_base_s, sx_nxt_s;
  logic [SUM_W-1:0] sy_r, sy_base_s, sy_nxt_s;
  logic [SUM_W-1:0] qx_s, qy_s;
  logic acc_on_r, last_r, snap_det_r;
  logic skin_s, abort_s, start_s, acc_s, skin_acc_s, at_end_s, last_acc_s;
  logic det_s, div_start_s, dx_done_s, dy_done_s, enter_done_s;
  logic skin_mask_r, mask_valid_r, cv_r, det_r, busy_r;
  logic [CX_W-1:0]  cx_r;
  logic [CY_W-1:0]  cy_r;
  logic [CNT_W-1:0] pc_r;
  logic unused_s;

  // Pixel classification and next values of the position counters and accumulators
  always_comb begin
    skin_s = (cb_in >= 8'(CB_MIN)) && (cb_in <= 8'(CB_MAX)) &&
             (cr_in >= 8'(CR_MIN)) && (cr_in <= 8'(CR_MAX));
    // A frame_start while a frame is still being collected aborts it; otherwise it opens a new one
    abort_s    = frame_start && (state_r == ACCUM) && !last_r;
    start_s    = frame_start && !abort_s;
    acc_s      = valid_in && (start_s || (acc_on_r && !frame_start));
    skin_acc_s = acc_s && skin_s;
    if (frame_start) begin
      x_base_s   = {XW{1'b0}};
      y_base_s   = {YW{1'b0}};
      cnt_base_s = {CNT_W{1'b0}};
      sx_base_s  = {SUM_W{1'b0}};
      sy_base_s  = {SUM_W{1'b0}};
    end else begin
      x_base_s   = x_r;
      y_base_s   = y_r;
      cnt_base_s = cnt_r;
      sx_base_s  = sx_r;
      sy_base_s  = sy_r;
    end
    at_end_s   = (x_base_s == XW'(H_RES - 1));
    last_acc_s = acc_s && at_end_s && (y_base_s == YW'(V_RES - 1));
    if (!acc_s) begin
      x_nxt_s = x_base_s;
      y_nxt_s = y_base_s;
    end else if (at_end_s) begin
      x_nxt_s = {XW{1'b0}};
      y_nxt_s = y_base_s + YW'(1);
    end else begin
      x_nxt_s = x_base_s + XW'(1);
      y_nxt_s = y_base_s;
    end
    cnt_nxt_s = cnt_base_s + {{(CNT_W-1){1'b0}}, skin_acc_s};
    if (skin_acc_s) begin
      sx_nxt_s = sx_base_s + {{(SUM_W-XW){1'b0}}, x_base_s};
      sy_nxt_s = sy_base_s + {{(SUM_W-YW){1'b0}}, y_base_s};
    end else begin
      sx_nxt_s = sx_base_s;
      sy_nxt_s = sy_base_s;
    end
    det_s       = (cnt_nxt_s >= CNT_W'(MIN_PIXELS));
    div_start_s = last_acc_s && det_s;
  end

  // Accumulator state and the end-of-frame snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r        <= {XW{1'b0}};
      y_r        <= {YW{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      sx_r       <= {SUM_W{1'b0}};
      sy_r       <= {SUM_W{1'b0}};
      acc_on_r   <= 1'b0;
      last_r     <= 1'b0;
      snap_cnt_r <= {CNT_W{1'b0}};
      snap_det_r <= 1'b0;
    end else begin
      x_r    <= x_nxt_s;
      y_r    <= y_nxt_s;
      cnt_r  <= cnt_nxt_s;
      sx_r   <= sx_nxt_s;
      sy_r   <= sy_nxt_s;
      last_r <= last_acc_s;
      if (last_acc_s) begin
        acc_on_r   <= 1'b0;
        snap_cnt_r <= cnt_nxt_s;
        snap_det_r <= det_s;
      end else if (start_s) begin
        acc_on_r <= 1'b1;
      end else if (abort_s) begin
        acc_on_r <= 1'b0;
      end
    end
  end

  seq_divider u_div_x (
    .clk(clk), .rst(rst), .start(div_start_s),
    .dividend(sx_nxt_s), .divisor(cnt_nxt_s), .quotient(qx_s), .done(dx_done_s)
  );

  seq_divider u_div_y (
    .clk(clk), .rst(rst), .start(div_start_s),
    .dividend(sy_nxt_s), .divisor(cnt_nxt_s), .quotient(qy_s), .done(dy_done_s)
  );

  // Frame control: decide one cycle after the last pixel, so both result paths share that edge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = ACCUM;
        else         state_nxt_s = IDLE;
      end
      ACCUM: begin
        if (abort_s)     state_nxt_s = IDLE;
        else if (last_r) state_nxt_s = snap_det_r ? DIVIDE : DONE;
        else             state_nxt_s = ACCUM;
      end
      DIVIDE: begin
        if (dx_done_s) state_nxt_s = DONE;
        else           state_nxt_s = DIVIDE;
      end
      DONE: begin
        if (acc_on_r || start_s) state_nxt_s = ACCUM;
        else                     state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
    enter_done_s = (state_nxt_s == DONE) && (state_r != DONE);
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      skin_mask_r  <= 1'b0;
      mask_valid_r <= 1'b0;
      cv_r         <= 1'b0;
      det_r        <= 1'b0;
      busy_r       <= 1'b0;
      cx_r         <= {CX_W{1'b0}};
      cy_r         <= {CY_W{1'b0}};
      pc_r         <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      skin_mask_r  <= valid_in && skin_s;
      mask_valid_r <= valid_in;
      cv_r         <= enter_done_s;
      busy_r       <= (state_nxt_s == DIVIDE);
      if (enter_done_s) begin
        pc_r  <= snap_cnt_r;
        det_r <= snap_det_r;
        // Below-threshold frames keep the last good centroid
        if (snap_det_r) begin
          cx_r <= qx_s[CX_W-1:0];
          cy_r <= qy_s[CY_W-1:0];
        end
      end
    end
  end

  assign unused_s = ^{y_in, qx_s[SUM_W-1:CX_W], qy_s[SUM_W-1:CY_W], dy_done_s};

  assign skin_mask      = skin_mask_r;
  assign mask_valid     = mask_valid_r;
  assign centroid_x     = cx_r;
  assign centroid_y     = cy_r;
  assign pixel_count    = pc_r;
  assign centroid_valid = cv_r;
  assign detected       = det_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_skin_centroid_tracker.sv
// Directed bench for skin_centroid_tracker on an 8x4 frame with MIN_PIXELS=4.
module tb_skin_centroid_tracker;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk, rst;
  logic [7:0]  y_in, cb_in, cr_in;
  logic        valid_in, frame_start;
  logic        skin_mask, mask_valid, centroid_valid, detected, busy;
  logic [8:0]  centroid_x;
  logic [7:0]  centroid_y;
  logic [16:0] pixel_count;

  int n_vec = 0;
  int n_err = 0;

  skin_centroid_tracker #(.H_RES(H), .V_RES(V), .MIN_PIXELS(4)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .valid_in(valid_in), .frame_start(frame_start),
    .skin_mask(skin_mask), .mask_valid(mask_valid),
    .centroid_x(centroid_x), .centroid_y(centroid_y), .pixel_count(pixel_count),
    .centroid_valid(centroid_valid), .detected(detected), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  // Frame patterns: 0 all skin, 1 block x=4..5 y=1..2, 2 three pixels on row 0
  function automatic bit skin_at(input int mode, input int x, input int y);
    case (mode)
      0:       return 1'b1;
      1:       return (x >= 4) && (x <= 5) && (y >= 1) && (y <= 2);
      2:       return (y == 0) && (x < 3);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_frame(input int mode, input int npix);
    for (int p = 0; p < npix; p++) begin
      @(negedge clk);
      frame_start = (p == 0);
      valid_in    = 1'b1;
      y_in        = 8'($urandom_range(0, 255));
      if (skin_at(mode, p % H, p / H)) begin
        cb_in = 8'd100; cr_in = 8'd150;
      end else if (p % 2 == 0) begin
        cb_in = 8'd50;  cr_in = 8'd150;
      end else begin
        cb_in = 8'd100; cr_in = 8'd200;
      end
    end
    @(negedge clk);
    valid_in    = 1'b0;
    frame_start = 1'b0;
  endtask

  // lat = k when the strobe is seen after edge N+k; -1 if it never comes
  task automatic wait_result(output int lat, output logic busy_mid);
    lat = -1;
    busy_mid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 10) busy_mid = busy;
      if (centroid_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input int lat, input int exp_lat,
                           input int cnt, input int cx, input int cy, input bit det);
    chk({tag, "_lat"},   32'(lat),         32'(exp_lat));
    chk({tag, "_count"}, 32'(pixel_count), 32'(cnt));
    chk({tag, "_cx"},    32'(centroid_x),  32'(cx));
    chk({tag, "_cy"},    32'(centroid_y),  32'(cy));
    chk({tag, "_det"},   32'(detected),    32'(det));
  endtask

  logic [7:0] cb_t [7] = '{8'd77, 8'd76, 8'd100, 8'd127, 8'd128, 8'd100, 8'd100};
  logic [7:0] cr_t [7] = '{8'd133, 8'd150, 8'd174, 8'd173, 8'd150, 8'd132, 8'd150};
  logic       vl_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       sk_t [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int   lat, la;
    logic bm, bm2;
    rst = 1'b1; valid_in = 1'b0; frame_start = 1'b0;
    y_in = 8'd0; cb_in = 8'd0; cr_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_cv",    32'(centroid_valid), 32'd0);
    chk("rst_det",   32'(detected),       32'd0);
    chk("rst_count", 32'(pixel_count),    32'd0);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_mv",    32'(mask_valid),     32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cb_in = cb_t[i]; cr_in = cr_t[i]; valid_in = vl_t[i];
      @(negedge clk);
      chk("mask", 32'(skin_mask), 32'(sk_t[i]));
      chk("mask_valid", 32'(mask_valid), 32'(vl_t[i]));
    end
    valid_in = 1'b0;

    // full skin frame
    send_frame(0, 32);
    wait_result(lat, bm);
    chk_frame("full", lat, 26, 32, 3, 1, 1'b1);
    chk("full_busy", 32'(bm), 32'd1);
    @(negedge clk);
    chk("strobe_1cyc", 32'(centroid_valid), 32'd0);

    send_frame(1, 32);
    wait_result(lat, bm);
    chk_frame("block", lat, 26, 4, 4, 1, 1'b1);

    // below threshold: centroid held from the block frame
    send_frame(2, 32);
    wait_result(lat, bm);
    chk_frame("few", lat, 1, 3, 4, 1, 1'b0);

    // abort after 10 pixels
    send_frame(0, 10);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_result(lat, bm);
    chk("abort_nostrobe", 32'(lat), 32'hFFFF_FFFF);
    chk("abort_count", 32'(pixel_count), 32'd3);
    send_frame(0, 32);
    wait_result(lat, bm);
    chk_frame("post_abort", lat, 26, 32, 3, 1, 1'b1);

    // reset in the middle of the division
    send_frame(1, 32);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_cv",    32'(centroid_valid), 32'd0);
    chk("mid_rst_count", 32'(pixel_count),    32'd0);
    chk("mid_rst_cx",    32'(centroid_x),     32'd0);
    chk("mid_rst_cy",    32'(centroid_y),     32'd0);
    chk("mid_rst_det",   32'(detected),       32'd0);
    chk("mid_rst_busy",  32'(busy),           32'd0);
    rst = 1'b0;
    wait_result(lat, bm);
    chk("mid_rst_nostrobe", 32'(lat), 32'hFFFF_FFFF);
    send_frame(1, 32);
    wait_result(lat, bm);
    chk_frame("post_rst", lat, 26, 4, 4, 1, 1'b1);

    // next frame starts while the previous one is still dividing
    send_frame(0, 32);
    fork
      begin
        wait_result(la, bm2);
        chk_frame("ovl_a", la, 26, 32, 3, 1, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        send_frame(1, 32);
      end
    join
    wait_result(lat, bm);
    chk_frame("ovl_b", lat, 26, 4, 4, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/skin_centroid_tracker.md
SKIN_CENTROID_TRACKER -- requirements
Module: skin_centroid_tracker

Interface
REQ-001 SHALL have parameter H_RES, default 320: active pixels per line.
REQ-002 SHALL have parameter V_RES, default 240: active lines per frame.
REQ-003 SHALL have parameters CB_MIN/CB_MAX, defaults 77/127, and CR_MIN/CR_MAX, defaults 133/173: inclusive skin window.
REQ-004 SHALL have parameter MIN_PIXELS, default 256: minimum skin count for a valid detection.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 y_in, cb_in, cr_in  in  8 each  pixel from the colour converter.
REQ-008 valid_in  in  1  pixel qualifier.
REQ-009 frame_start  in  1  one-cycle pulse marking the start of a frame.
REQ-010 skin_mask  out  1  per-pixel skin decision; mask_valid  out  1  its qualifier.
REQ-011 centroid_x  out  9, centroid_y  out  8  centroid of skin pixels.
REQ-012 pixel_count  out  17  skin-pixel count of the last completed frame.
REQ-013 centroid_valid  out  1  one-cycle result strobe; detected  out  1  count >= MIN_PIXELS; busy  out  1  high while dividing.

Function
REQ-014 A pixel SHALL be skin iff CB_MIN<=cb_in<=CB_MAX and CR_MIN<=cr_in<=CR_MAX; y_in SHALL be ignored.
REQ-015 skin_mask and mask_valid SHALL be registered with 1-cycle latency from valid_in; skin_mask is 0 when mask_valid is 0.
REQ-016 Internal x (0..H_RES-1) and y (0..V_RES-1) counters SHALL advance on each accepted pixel; x SHALL wrap to 0 and increment y at H_RES-1.
REQ-017 frame_start SHALL clear x, y, count, sum_x and sum_y; if valid_in coincides, that pixel SHALL be accumulated as (0,0) of the new frame.
REQ-018 Accumulators SHALL be 17-bit count and 25-bit sum_x and sum_y; skin pixels add x and y to them.
REQ-019 Pixels after (H_RES-1,V_RES-1) and before the next frame_start SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, ACCUM, DIVIDE, DONE; reset enters IDLE.
REQ-021 IDLE->ACCUM on frame_start; ACCUM->IDLE on frame_start, which aborts the frame with no output.
REQ-022 Acceptance of pixel (H_RES-1,V_RES-1) SHALL snapshot the accumulators into divider registers and move to DIVIDE, or to DONE if count<MIN_PIXELS.
REQ-023 DIVIDE SHALL compute floor(sum_x/count) and floor(sum_y/count) in parallel by restoring division, 25 iterations, one per cycle; busy=1 throughout.
REQ-024 DONE SHALL last one cycle with centroid_valid=1, then return to IDLE. Outputs SHALL update on the DONE edge.
REQ-025 Edge N accepts the last pixel. When count>=MIN_PIXELS, centroid_valid SHALL be high in the cycle after edge N+26.
REQ-026 When count<MIN_PIXELS, DONE SHALL follow edge N+1. In that case detected=0, pixel_count updates, and centroid_x/centroid_y hold their previous values.
REQ-027 A frame_start during DIVIDE or DONE SHALL start accumulating the new frame without disturbing the division in flight.
REQ-028 After DONE, the FSM SHALL go to ACCUM, not IDLE, if a frame_start was seen during DIVIDE or DONE.

Reset
REQ-029 Reset SHALL clear all outputs, counters, accumulators and divider registers to 0 and enter IDLE, including mid-DIVIDE, with no centroid_valid.

Structure
REQ-030 The state encoding and the accumulator and result widths SHALL be in the shared package ycbcr_pkg.
REQ-031 Division SHALL use one sub-module, seq_divider (25-bit dividend, 17-bit divisor, start/done), instantiated twice.

Verification (bench parameters: H_RES=8, V_RES=4, MIN_PIXELS=4)
REQ-032 All 32 pixels cb=100, cr=150 -> pixel_count=32, centroid_x=3, centroid_y=1, detected=1, centroid_valid after edge N+26.
REQ-033 Skin only at x=4..5, y=1..2 -> pixel_count=4, centroid_x=4, centroid_y=1, detected=1.
REQ-034 Thresholds: cb=77, cr=133 -> skin_mask=1; cb=76 or cr=174 -> skin_mask=0, one cycle after valid_in.
REQ-035 Three skin pixels -> centroid_valid after edge N+1, detected=0, pixel_count=3, previous centroid held.
REQ-036 frame_start at pixel 10 of a frame -> no centroid_valid for the aborted frame; the next full frame gives correct results.
REQ-037 rst asserted at DIVIDE cycle 12 -> all outputs 0, IDLE, no strobe; the next frame after release is correct.
